// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop line synchroniser, start-edge detect, 2-of-3 mid-bit
// majority vote, optional parity and 1/2 stop bits, with accept/parity/framing pulses.
module uart_rx_oversampled #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                           CLK_BPS,
  input  logic                           reset,
  input  logic                           uart_txd_in,
  output logic [DATA_BITS-1:0]           receive_data,
  output logic [$clog2(DATA_BITS+1)-1:0] receive_data_counter,
  output logic                           accept,
  output logic                           parity_error,
  output logic                           frame_error,
  output logic                           busy
);

  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [PH_W-1:0]  PH_S0     = PH_W'(M - 1);
  localparam logic [PH_W-1:0]  PH_S1     = PH_W'(M);
  localparam logic [PH_W-1:0]  PH_VOTE   = PH_W'(M + 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_BITS);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic                   perr_q, perr_d;
  logic                   sbad_q, sbad_d;
  logic                   sidx_q, sidx_d;
  logic                   acc_q, acc_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;

  logic rxs;
  logic vote;
  logic at_vote;
  logic at_last;
  logic stop_fail;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd mode wants an odd population over data+parity, even mode an even one.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic odd_pop;
    odd_pop = ^{d, p};
    return (PARITY_MODE == 1) ? ~odd_pop : odd_pop;
  endfunction

  assign rxs       = sync2_q;
  assign vote      = majority3(s0_q, s1_q, rxs);
  assign at_vote   = (ph_q == PH_VOTE);
  assign at_last   = (ph_q == PH_LAST);
  assign stop_fail = sbad_q | ~vote;

  always_comb begin
    state_d = state_q;
    sync1_d = uart_txd_in;
    sync2_d = sync1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    perr_d  = perr_q;
    sbad_d  = sbad_q;
    sidx_d  = sidx_q;
    acc_d   = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;

    if (state_q != IDLE && state_q != WAIT_HIGH) begin
      ph_d = at_last ? '0 : ph_q + 1'b1;
      if (ph_q == PH_S0) s0_d = rxs;
      if (ph_q == PH_S1) s1_d = rxs;
    end

    case (state_q)
      IDLE: begin
        ph_d   = '0;
        cnt_d  = '0;
        perr_d = 1'b0;
        sbad_d = 1'b0;
        sidx_d = 1'b0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (at_vote && vote) state_d = IDLE;
        else if (at_last)    state_d = DATA;
      end
      DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
        if (at_last && cnt_q == CNT_FULL) begin
          if (PARITY_MODE != 0) begin
            state_d = PARITY;
          end else begin
            state_d = STOP;
            cnt_d   = '0;
          end
        end
      end
      PARITY: begin
        if (at_vote) perr_d = parity_bad(shift_q, vote);
        if (at_last) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
      STOP: begin
        // The frame completes on the last stop vote rather than at the end of the bit,
        // leaving room for the next start edge even with a slightly fast transmitter.
        if (at_vote) begin
          sbad_d = stop_fail;
          if (sidx_q == LAST_STOP) begin
            rdata_d = shift_q;
            acc_d   = ~perr_q & ~stop_fail;
            pe_d    = perr_q;
            fe_d    = stop_fail;
            state_d = stop_fail ? WAIT_HIGH : IDLE;
          end
        end else if (at_last) begin
          sidx_d = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_BPS or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      ph_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
      sbad_q  <= 1'b0;
      sidx_q  <= 1'b0;
      acc_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
      sbad_q  <= sbad_d;
      sidx_q  <= sidx_d;
      acc_q   <= acc_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  // Assembly register is pure datapath; it is only observed after a full frame.
  always_ff @(posedge CLK_BPS) begin
    shift_q <= shift_d;
  end

  assign receive_data         = rdata_q;
  assign receive_data_counter = cnt_q;
  assign accept               = acc_q;
  assign parity_error         = pe_q;
  assign frame_error          = fe_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: three configurations (8N1, 8E1, 8N2) driven with directed
// and random frames; outcomes come from a frame-level reference model.
module tb_uart_rx_oversampled;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic line_n1 = 1'b1;
  logic line_e1 = 1'b1;
  logic line_n2 = 1'b1;

  logic [7:0] rd_n1, rd_e1, rd_n2;
  logic [3:0] cnt_n1, cnt_e1, cnt_n2;
  logic acc_n1, pe_n1, fe_n1, busy_n1;
  logic acc_e1, pe_e1, fe_e1, busy_e1;
  logic acc_n2, pe_n2, fe_n2, busy_n2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       acc;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t q_n1[$];
  ev_t q_e1[$];
  ev_t q_n2[$];

  always #5 clk = ~clk;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) dut_n1 (
    .CLK_BPS(clk), .reset(rst), .uart_txd_in(line_n1), .receive_data(rd_n1),
    .receive_data_counter(cnt_n1), .accept(acc_n1), .parity_error(pe_n1),
    .frame_error(fe_n1), .busy(busy_n1));

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(1)) dut_e1 (
    .CLK_BPS(clk), .reset(rst), .uart_txd_in(line_e1), .receive_data(rd_e1),
    .receive_data_counter(cnt_e1), .accept(acc_e1), .parity_error(pe_e1),
    .frame_error(fe_e1), .busy(busy_e1));

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(2)) dut_n2 (
    .CLK_BPS(clk), .reset(rst), .uart_txd_in(line_n2), .receive_data(rd_n2),
    .receive_data_counter(cnt_n2), .accept(acc_n2), .parity_error(pe_n2),
    .frame_error(fe_n2), .busy(busy_n2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Every pulse cycle becomes one event; accept must never coincide with an error pulse.
  always @(negedge clk) begin
    if (acc_n1 | pe_n1 | fe_n1) begin
      q_n1.push_back('{rd_n1, acc_n1, pe_n1, fe_n1});
      chk("n1_excl", 32'(acc_n1 & (pe_n1 | fe_n1)), 32'd0);
    end
    if (acc_e1 | pe_e1 | fe_e1) begin
      q_e1.push_back('{rd_e1, acc_e1, pe_e1, fe_e1});
      chk("e1_excl", 32'(acc_e1 & (pe_e1 | fe_e1)), 32'd0);
    end
    if (acc_n2 | pe_n2 | fe_n2) begin
      q_n2.push_back('{rd_n2, acc_n2, pe_n2, fe_n2});
      chk("n2_excl", 32'(acc_n2 & (pe_n2 | fe_n2)), 32'd0);
    end
  end

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       line_n1 = v;
      1:       line_e1 = v;
      default: line_n2 = v;
    endcase
  endtask

  task automatic hold(input int d, input logic v, input int n);
    set_line(d, v);
    repeat (n) @(negedge clk);
  endtask

  task automatic outs(input int d, output logic [7:0] rd, output logic [3:0] cnt,
                      output logic a, output logic p, output logic f, output logic b);
    case (d)
      0:       begin rd = rd_n1; cnt = cnt_n1; a = acc_n1; p = pe_n1; f = fe_n1; b = busy_n1; end
      1:       begin rd = rd_e1; cnt = cnt_e1; a = acc_e1; p = pe_e1; f = fe_e1; b = busy_e1; end
      default: begin rd = rd_n2; cnt = cnt_n2; a = acc_n2; p = pe_n2; f = fe_n2; b = busy_n2; end
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q_n1.size();
      1:       return q_e1.size();
      default: return q_n2.size();
    endcase
  endfunction

  task automatic check_zero(input int d, input string tag);
    logic [7:0] rd; logic [3:0] cnt; logic a, p, f, b;
    outs(d, rd, cnt, a, p, f, b);
    chk($sformatf("%s_d%0d_outs", tag, d), {rd, cnt, a, p, f, b}, 32'd0);
  endtask

  task automatic check_idle(input int d, input logic [7:0] rd_exp, input string tag);
    logic [7:0] rd; logic [3:0] cnt; logic a, p, f, b;
    outs(d, rd, cnt, a, p, f, b);
    chk($sformatf("%s_d%0d_busy", tag, d), 32'(b), 32'd0);
    chk($sformatf("%s_d%0d_cnt", tag, d), 32'(cnt), 32'd0);
    chk($sformatf("%s_d%0d_data", tag, d), 32'(rd), 32'(rd_exp));
  endtask

  task automatic check_no_ev(input int d, input string tag);
    chk($sformatf("%s_d%0d_no_event", tag, d), 32'(qsize(d)), 32'd0);
  endtask

  task automatic expect_ev(input int d, input string tag, input logic [7:0] data,
                           input logic a, input logic p, input logic f);
    ev_t e;
    chk($sformatf("%s_d%0d_event", tag, d), 32'(qsize(d) > 0), 32'd1);
    if (qsize(d) > 0) begin
      case (d)
        0:       e = q_n1.pop_front();
        1:       e = q_e1.pop_front();
        default: e = q_n2.pop_front();
      endcase
      chk($sformatf("%s_d%0d_flags", tag, d), {29'd0, e.acc, e.pe, e.fe}, {29'd0, a, p, f});
      chk($sformatf("%s_d%0d_rxdata", tag, d), 32'(e.data), 32'(data));
    end
  endtask

  // Line-level frame: d=0 8N1, d=1 8E1 (pbit sent as given), d=2 8N2. stops[0] is the first stop.
  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input int gbit);
    hold(d, 1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        hold(d, data[i], M);
        hold(d, ~data[i], 1);
        hold(d, data[i], OS - M - 1);
      end else begin
        hold(d, data[i], OS);
      end
    end
    if (d == 1) hold(d, pbit, OS);
    hold(d, stops[0], OS);
    if (d == 2) hold(d, stops[1], OS);
  endtask

  // Frame-level outcome: even parity over data+parity bit, every stop bit must be 1;
  // a single-cycle glitch never changes the received payload.
  function automatic logic stops_ok(input int d, input logic [1:0] stops);
    return (d == 2) ? (stops == 2'b11) : stops[0];
  endfunction

  task automatic expect_model(input int d, input string tag, input logic [7:0] data,
                              input logic pbit, input logic [1:0] stops);
    logic pok, sok;
    pok = (d != 1) || ((($countones(data) + int'(pbit)) % 2) == 0);
    sok = stops_ok(d, stops);
    expect_ev(d, tag, data, pok & sok, ~pok, ~sok);
  endtask

  initial begin
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;
    int         gbit;
    int         gap;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0, "reset_hold");
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_zero(d, "reset");

    // 8N1 0xA5
    send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
    expect_model(0, "a5", 8'hA5, 1'b0, 2'b11);
    check_idle(0, 8'hA5, "a5");
    hold(0, 1'b1, OS);
    check_no_ev(0, "a5_single");

    // false start
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 3 * OS);
    check_no_ev(0, "false_start");
    check_idle(0, 8'hA5, "false_start");

    // even parity 0x37: wrong then right parity bit
    send_frame(1, 8'h37, 1'b0, 2'b11, -1);
    hold(1, 1'b1, 4);
    expect_ev(1, "par_bad", 8'h37, 1'b0, 1'b1, 1'b0);
    send_frame(1, 8'h37, 1'b1, 2'b11, -1);
    hold(1, 1'b1, 4);
    expect_ev(1, "par_good", 8'h37, 1'b1, 1'b0, 1'b0);

    // broken stop followed by a 40-bit break
    send_frame(0, 8'h12, 1'b0, 2'b00, -1);
    hold(0, 1'b0, 40 * OS);
    expect_ev(0, "break", 8'h12, 1'b0, 1'b0, 1'b1);
    check_no_ev(0, "break_single");
    chk("break_busy", 32'(busy_n1), 32'd1);
    hold(0, 1'b1, 2 * OS);
    check_idle(0, 8'h12, "break_end");
    send_frame(0, 8'h5A, 1'b0, 2'b11, -1);
    expect_ev(0, "after_break", 8'h5A, 1'b1, 1'b0, 1'b0);

    // mid-bit glitches rejected by the vote
    hold(0, 1'b1, OS);
    send_frame(0, 8'h00, 1'b0, 2'b11, 3);
    expect_ev(0, "glitch_hi", 8'h00, 1'b1, 1'b0, 1'b0);
    hold(0, 1'b1, OS);
    send_frame(0, 8'hFF, 1'b0, 2'b11, 3);
    expect_ev(0, "glitch_lo", 8'hFF, 1'b1, 1'b0, 1'b0);
    hold(0, 1'b1, OS);

    // reset in the middle of data bit 4
    data = 8'hC6;
    hold(0, 1'b0, OS);
    for (int i = 0; i < 4; i++) hold(0, data[i], OS);
    hold(0, data[4], 2);
    chk("mid_cnt", 32'(cnt_n1), 32'd4);
    chk("mid_busy", 32'(busy_n1), 32'd1);
    hold(0, data[4], 2);
    rst = 1'b1;
    #1;
    check_zero(0, "mid_reset");
    set_line(0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(0, 1'b1, 2 * OS);
    check_no_ev(0, "mid_reset");
    check_zero(0, "mid_reset_after");

    // two stop bits, back to back
    send_frame(2, 8'hC3, 1'b0, 2'b11, -1);
    send_frame(2, 8'h3C, 1'b0, 2'b11, -1);
    hold(2, 1'b1, 4);
    expect_ev(2, "b2b_0", 8'hC3, 1'b1, 1'b0, 1'b0);
    expect_ev(2, "b2b_1", 8'h3C, 1'b1, 1'b0, 1'b0);
    check_no_ev(2, "b2b");

    // random frames on every configuration
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 25; k++) begin
        data  = 8'($urandom);
        pbit  = 1'($urandom_range(0, 1));
        stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        gbit  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
        send_frame(d, data, pbit, stops, gbit);
        expect_model(d, $sformatf("rnd%0d", k), data, pbit, stops);
        gap = stops_ok(d, stops) ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
        hold(d, 1'b1, gap);
      end
      hold(d, 1'b1, 2 * OS);
      check_no_ev(d, "rnd_end");
      chk($sformatf("rnd_end_d%0d_busy", d), 32'(d == 0 ? busy_n1 : (d == 1 ? busy_e1 : busy_n2)), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
